// File: rtl/tt_capture_bank.sv
// Multi-channel time-tag capture bank: free-running tick counter with one self-clearing
// capture slot per trigger channel. Optional macro TT_TRIG_SYNC_EN adds two-flop trigger synchronisers.
module tt_capture_bank #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic [NCH-1:0]   trig,
  input  logic [SELW-1:0]  rd_sel,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [NCH-1:0]   valid,
  output logic [NCH-1:0]   lost,
  output logic [WIDTH-1:0] count
);

  logic [NCH-1:0]   trig_s;
  logic [NCH-1:0]   trig_d;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   rd_hit;
  logic [WIDTH-1:0] cap [NCH];

`ifdef TT_TRIG_SYNC_EN
  logic [NCH-1:0] trig_p0;
  logic [NCH-1:0] trig_p1;

  // Synchroniser stages p0 -> p1 for asynchronous trigger sources
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_p0 <= '0;
      trig_p1 <= '0;
    end else begin
      trig_p0 <= trig;
      trig_p1 <= trig_p0;
    end
  end

  assign trig_s = trig_p1;
`else
  assign trig_s = trig;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (cnt_clr) begin
      count <= '0;
    end else if (cnt_en) begin
      count <= count + 1'b1;
    end
  end

  // Edge history stage; resetting to 0 lets a trigger held high through reset capture at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_d <= '0;
    end else begin
      trig_d <= trig_s;
    end
  end

  always_comb begin
    rise   = trig_s & ~trig_d;
    rd_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_hit[i] = rd && (rd_sel == SELW'(i));
    end
  end

  // A read in the same cycle as a rise frees the slot, so the new tag loads without loss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cap[i] <= '0;
      end
      valid <= '0;
      lost  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rise[i]) begin
          if (!valid[i] || rd_hit[i]) begin
            cap[i]   <= count;
            valid[i] <= 1'b1;
            if (rd_hit[i]) begin
              lost[i] <= 1'b0;
            end
          end else begin
            lost[i] <= 1'b1;
          end
        end else if (rd_hit[i]) begin
          valid[i] <= 1'b0;
          lost[i]  <= 1'b0;
        end
      end
    end
  end

  // Out-of-range selects match no channel and read back as zero
  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == SELW'(i)) begin
        rd_data  = cap[i];
        rd_valid = valid[i];
      end
    end
  end

endmodule
